// File: rtl/srec_word_packer.sv
// Packs the srec_parser byte-write stream into aligned 32-bit words with byte
// enables, presented on a valid/ready port to a program-RAM loader.
module srec_word_packer #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] write_address,
   input  logic [7:0]  write_byte,
   input  logic        write_enable,
   input  logic        in_progress,
   output logic [31:0] word_address,
   output logic [31:0] word_data,
   output logic [3:0]  word_byte_enable,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        overflow
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BE_W    = 4;
   localparam int unsigned WADDR_W = 30;

   logic [WADDR_W-1:0] acc_addr_q, acc_addr_d;
   logic [DATA_W-1:0]  acc_data_q, acc_data_d;
   logic [BE_W-1:0]    acc_be_q,   acc_be_d;

   logic [DATA_W-1:0]  out_addr_q, out_addr_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic [BE_W-1:0]    out_be_q,   out_be_d;
   logic               out_valid_q, out_valid_d;
   logic               overflow_q, overflow_d;

   logic [1:0]         lane;
   logic [1:0]         byte_pos;
   logic [DATA_W-1:0]  lane_data;
   logic [BE_W-1:0]    lane_be;
   logic               acc_empty;
   logic               acc_full;
   logic               same_word;
   logic               lane_taken;
   logic               out_free;
   logic               forced_flush;
   logic               end_flush;
   logic               do_flush;

   // Incoming byte positioned into its lane.
   always_comb begin
      lane      = write_address[1:0];
      byte_pos  = BIG_ENDIAN ? (2'd3 - lane) : lane;
      lane_data = {24'h0, write_byte} << {byte_pos, 3'b000};
      lane_be   = 4'b0001 << lane;
   end

   // Flush decision: a full accumulator or a conflicting write forces a flush;
   // a partial word only leaves once parsing is over and the output is free.
   always_comb begin
      acc_empty    = (acc_be_q == 4'b0000);
      acc_full     = (acc_be_q == 4'b1111);
      same_word    = (write_address[31:2] == acc_addr_q);
      lane_taken   = ((acc_be_q & lane_be) != 4'b0000);
      out_free     = !out_valid_q || word_ready;
      forced_flush = acc_full ||
                     (write_enable && !acc_empty && (!same_word || lane_taken));
      end_flush    = !acc_empty && !in_progress && !write_enable && out_free;
      do_flush     = forced_flush || end_flush;
   end

   // Next state for accumulator, output register and sticky overflow.
   always_comb begin
      acc_addr_d  = acc_addr_q;
      acc_data_d  = acc_data_q;
      acc_be_d    = acc_be_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_be_d    = out_be_q;
      out_valid_d = out_valid_q;
      overflow_d  = overflow_q;

      if (out_valid_q && word_ready) begin
         out_valid_d = 1'b0;
      end

      if (do_flush) begin
         if (out_free) begin
            out_addr_d  = {acc_addr_q, 2'b00};
            out_data_d  = acc_data_q;
            out_be_d    = acc_be_q;
            out_valid_d = 1'b1;
         end else begin
            overflow_d  = 1'b1;
         end
         acc_data_d = '0;
         acc_be_d   = '0;
      end

      if (write_enable) begin
         if (acc_empty || do_flush) begin
            acc_addr_d = write_address[31:2];
            acc_data_d = lane_data;
            acc_be_d   = lane_be;
         end else begin
            acc_data_d = acc_data_q | lane_data;
            acc_be_d   = acc_be_q | lane_be;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         acc_addr_q  <= '0;
         acc_data_q  <= '0;
         acc_be_q    <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_be_q    <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         acc_addr_q  <= acc_addr_d;
         acc_data_q  <= acc_data_d;
         acc_be_q    <= acc_be_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_be_q    <= out_be_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign word_address     = out_addr_q;
   assign word_data        = out_data_q;
   assign word_byte_enable = out_be_q;
   assign word_valid       = out_valid_q;
   assign overflow         = overflow_q;

endmodule

// File: doc/srec_word_packer.md
Name: srec_word_packer

Overview:
- Downstream of srec_parser: consumes its byte-write stream (write_address, write_byte, write_enable, in_progress).
- Packs bytes into aligned 32-bit words with per-byte enables and presents them on a valid/ready port to a memory writer (program RAM loader).
- Cuts the memory-side write rate by 4x and tolerates sparse or out-of-order S-record data.

Parameters:
- BIG_ENDIAN, 1, byte lane mapping: 1 means address offset 0 goes to word_data[31:24]; 0 means offset 0 goes to word_data[7:0].

Ports:
- clock  input  1  system clock, single clock domain
- reset_n  input  1  synchronous, active-low reset
- write_address  input  32  byte address from srec_parser
- write_byte  input  8  byte data
- write_enable  input  1  one-cycle strobe; address and data valid when high
- in_progress  input  1  high while an S-record file is being parsed
- word_address  output  32  word address of the output word, bits [1:0] always 0
- word_data  output  32  packed data; lanes not enabled read 0
- word_byte_enable  output  4  bit i set means byte at word_address+i is valid
- word_valid  output  1  output word present
- word_ready  input  1  consumer accepts the word when word_valid && word_ready
- overflow  output  1  sticky: a word was dropped due to backpressure

Behaviour:
- All state updates on posedge clock.
- Reset applies when reset_n==0 at the edge. It overrides everything, including mid-word and mid-handshake:
  - word_address=0, word_data=0, word_byte_enable=0, word_valid=0, overflow=0
  - accumulator empty (acc_be=0, acc_addr=0, acc_data=0)
- Two storage stages:
  - accumulator: acc_addr[31:2], acc_data, acc_be
  - output register: drives word_* outputs
- lane = write_address[1:0].
  - BIG_ENDIAN=1: byte goes to bits [31-8*lane -: 8].
  - BIG_ENDIAN=0: byte goes to bits [8*lane +: 8].
  - word_byte_enable bit index is always lane, regardless of BIG_ENDIAN.
- out_free = !word_valid || word_ready.
- On write_enable, exactly one case applies:
  - (a) Accumulator empty: load the byte and its lane; acc_addr = write_address[31:2].
  - (b) Same word address and lane not yet set: merge the byte.
  - (c) Different word address, or lane already set (duplicate write): flush the accumulator, then load the new byte as in (a).
- Full flush: if acc_be becomes 4'b1111 after a merge, the accumulator flushes on the next edge, so it always flushes a complete word.
  - Latency: the 4th byte accepted at edge N gives word_valid=1 after edge N+1.
  - If a write_enable arrives at edge N+1, the full flush and the new-byte load occur together, as in case (c).
- End flush: accumulator non-empty, in_progress==0, write_enable==0, and out_free. The partial word is flushed.
  - While in_progress==1, partial words are held indefinitely.
- A flush moves the accumulator into the output register with word_valid=1. The accumulator then holds only the new byte (if any) or becomes empty.
- Flush with !out_free:
  - Forced flush (cases (c) or full): the accumulator word is discarded, overflow is set to 1 and stays set until reset, and the new byte still loads. Output register unchanged.
  - End flush: simply waits; no loss.
- Output handshake:
  - word_* stay stable while word_valid && !word_ready.
  - Transfer when word_valid && word_ready. word_valid clears next edge unless a flush refills it in the same cycle (back-to-back).
- word_address = {acc_addr, 2'b00} captured at flush.
- write_enable with in_progress==0 is still accepted.
- No address wrap handling is needed: 0xFFFFFFFC and 0x00000000 are different words.

Test Plan:
- Full word, BIG_ENDIAN=1, word_ready=1: bytes 0x11,0x22,0x33,0x44 to 0x1000..0x1003 on consecutive cycles. Required: one word, addr 0x1000, data 0x11223344, be 4'b1111, word_valid high exactly 1 cycle, one cycle after the 4th byte.
- Same stream with BIG_ENDIAN=0 -> data 0x44332211.
- Partial and end flush: bytes 0xAA@0x2001 and 0xBB@0x2002, then in_progress falls. Required: word addr 0x2000, data 0x00AABB00, be 4'b0110; nothing emitted while in_progress is still high.
- Discontinuity: 0x01@0x3000 then 0x02@0x4003. Required: word (0x3000, 0x01000000, 4'b0001), then at end flush word (0x4000, 0x00000002, 4'b1000). Duplicate write 0x05@0x3000 twice gives two separate words.
- Backpressure: word_ready=0, fill 0x1000..0x1003, then 0x1004..0x1007. Required: first word held stable, second dropped, overflow=1. When word_ready=1 the first word transfers; overflow stays 1.
- Reset mid-word: 2 bytes loaded, reset_n=0 one cycle. Required: all outputs 0, accumulator empty, and a subsequent in_progress low emits nothing.
